wb_stage_q: RTL and testbench

Parametrised successor to the single-cycle writeback stage, sitting between MEM and the register file. It buffers retiring instructions in a small in-order queue and holds loads at the head until their memory response arrives, so data memory may have variable latency. It extracts and sign- or zero-extends load data by byte offset, then selects among load data, ALU result and PC+4. Register-file write outputs are registered.

---
 rtl/wb_stage_q.sv | 184 ++++++++++++++++++
 tb/tb_wb_stage_q.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_q.sv
// Generic show-ahead FIFO: head entry is visible on dout whenever not empty.
// Latency: a pushed entry appears on dout the cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty; full is registered-count based.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// In-order writeback queue: holds loads at the head until their memory response, then writes the RF.
// Latency: non-load retires one edge after enqueue; load retires on the edge sampling mem_rvalid.
// Backpressure: in_ready = !full (registered count), so a retiring full queue frees its slot a cycle later.
module wb_stage_q #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_memtoreg,
    input  logic              in_regwrite,
    input  logic              in_pc2reg,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              err_rsp,
    output logic              err_f3
);
    typedef struct packed {
        logic              memtoreg;
        logic              regwrite;
        logic              pc2reg;
        logic [2:0]        funct3;
        logic [1:0]        addr_lo;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   pc4;
    } entry_t;

    entry_t    in_ent;
    entry_t    head;
    logic      empty;
    logic      full;
    logic      retire;
    logic      rsp_drop;
    logic      f3_bad;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wdata;

    assign in_ent = '{memtoreg: in_memtoreg, regwrite: in_regwrite, pc2reg: in_pc2reg,
                      funct3: in_funct3, addr_lo: in_addr_lo, rd: in_rd,
                      alu: in_alu_result, pc4: in_pc_plus4};

    wb_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .din   (in_ent),
        .pop   (retire),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    assign in_ready = !full;
    // A load head waits for its response; anything else leaves as soon as it is at the head.
    assign retire   = !empty && (!head.memtoreg || mem_rvalid);
    // A response is only meaningful when a load sits at the head.
    assign rsp_drop = mem_rvalid && (empty || !head.memtoreg);

    // Pick the addressed byte/half from the aligned word and extend per funct3.
    always_comb begin
        f3_bad  = 1'b0;
        ld_data = '0;
        case (head.addr_lo)
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            2'd3:    ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = head.addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (head.funct3)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b010:  ld_data = mem_rdata;
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: f3_bad  = 1'b1;
        endcase
        if (head.pc2reg)        wdata = head.pc4;
        else if (head.memtoreg) wdata = ld_data;
        else                    wdata = head.alu;
    end

    // Registered RF write port; address/data hold when nothing retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (retire) begin
            rf_we    <= head.regwrite && (head.rd != '0);
            rf_waddr <= head.rd;
            rf_wdata <= wdata;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_rsp <= 1'b0;
            err_f3  <= 1'b0;
        end else begin
            if (rsp_drop)                           err_rsp <= 1'b1;
            if (retire && head.memtoreg && f3_bad)  err_f3  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_stage_q.sv
module tb_wb_stage_q;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_memtoreg;
    logic        in_regwrite;
    logic        in_pc2reg;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err_rsp;
    logic        err_f3;

    int n_checks = 0;
    int n_pass   = 0;

    wb_stage_q #(.XLEN(32), .REG_AW(5), .DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_memtoreg   (in_memtoreg),
        .in_regwrite   (in_regwrite),
        .in_pc2reg     (in_pc2reg),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .err_rsp       (err_rsp),
        .err_f3        (err_f3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_memtoreg = 0; in_regwrite = 0; in_pc2reg = 0;
        in_funct3 = 0; in_addr_lo = 0; in_rd = 0; in_alu_result = 0; in_pc_plus4 = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic drive(input logic m2r, input logic rw, input logic p2r, input logic [2:0] f3,
                         input logic [1:0] off, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc4);
        in_valid = 1; in_memtoreg = m2r; in_regwrite = rw; in_pc2reg = p2r;
        in_funct3 = f3; in_addr_lo = off; in_rd = rd; in_alu_result = alu; in_pc_plus4 = pc4;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        #3;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_we got %b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_waddr !== 5'd0) $display("FAIL reset_waddr got %0d want 0", rf_waddr); else n_pass++;
        n_checks++; if (rf_wdata !== 32'd0) $display("FAIL reset_wdata got %h want 0", rf_wdata); else n_pass++;
        n_checks++; if (err_rsp !== 1'b0 || err_f3 !== 1'b0) $display("FAIL reset_err got %b%b want 00", err_rsp, err_f3); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else n_pass++;
        tick();
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_alu();
        drive(0, 1, 0, 3'b000, 2'd0, 5'd5, 32'h1234_5678, 32'h0);
        tick();
        idle();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL alu_early_we got %b want 0", rf_we); else n_pass++;
        tick();
        n_checks++; if (rf_we !== 1'b1) $display("FAIL alu_we got %b want 1", rf_we); else n_pass++;
        n_checks++; if (rf_waddr !== 5'd5) $display("FAIL alu_waddr got %0d want 5", rf_waddr); else n_pass++;
        n_checks++; if (rf_wdata !== 32'h1234_5678) $display("FAIL alu_wdata got %h want 12345678", rf_wdata); else n_pass++;
        tick();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL alu_we_drop got %b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) $display("FAIL alu_hold got %0d/%h want 5/12345678", rf_waddr, rf_wdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 0, 3'b000, 2'd0, 5'd1, 32'h11, 32'h0);
        tick();
        drive(0, 1, 0, 3'b000, 2'd0, 5'd2, 32'h22, 32'h0);
        tick();
        idle();
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h11) $display("FAIL b2b_first got %b/%0d/%h want 1/1/11", rf_we, rf_waddr, rf_wdata); else n_pass++;
        tick();
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22) $display("FAIL b2b_second got %b/%0d/%h want 1/2/22", rf_we, rf_waddr, rf_wdata); else n_pass++;
        tick();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL b2b_idle got %b want 0", rf_we); else n_pass++;
    endtask

    task automatic test_loads();
        logic [2:0]  f3v [4] = '{3'b000, 3'b101, 3'b001, 3'b010};
        logic [1:0]  offv[4] = '{2'd3, 2'd2, 2'd0, 2'd1};
        logic [31:0] expv[4] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'h0000_1234, 32'h80FF_1234};
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, f3v[i], offv[i], 5'(10 + i), 32'hDEAD_BEEF, 32'h0);
            tick();
            idle();
            mem_rvalid = 1;
            mem_rdata  = 32'h80FF_1234;
            tick();
            idle();
            n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + i)) $display("FAIL load%0d_we got %b/%0d want 1/%0d", i, rf_we, rf_waddr, 10 + i); else n_pass++;
            n_checks++; if (rf_wdata !== expv[i]) $display("FAIL load%0d_data got %h want %h", i, rf_wdata, expv[i]); else n_pass++;
        end
        n_checks++; if (err_f3 !== 1'b0) $display("FAIL f3_clean got %b want 0", err_f3); else n_pass++;
        drive(1, 1, 0, 3'b011, 2'd0, 5'd14, 32'hDEAD_BEEF, 32'h0);
        tick();
        idle();
        mem_rvalid = 1;
        mem_rdata  = 32'h80FF_1234;
        tick();
        idle();
        n_checks++; if (rf_wdata !== 32'h0) $display("FAIL f3_bad_data got %h want 0", rf_wdata); else n_pass++;
        n_checks++; if (err_f3 !== 1'b1) $display("FAIL f3_bad_err got %b want 1", err_f3); else n_pass++;
    endtask

    task automatic test_rd0_pc2reg();
        drive(0, 1, 0, 3'b000, 2'd0, 5'd0, 32'h55, 32'h0);
        tick();
        idle();
        tick();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rd0_we got %b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'h55) $display("FAIL rd0_data got %0d/%h want 0/55", rf_waddr, rf_wdata); else n_pass++;
        drive(0, 1, 1, 3'b000, 2'd0, 5'd7, 32'h99, 32'h0000_0104);
        tick();
        idle();
        tick();
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h0000_0104) $display("FAIL pc2reg got %b/%0d/%h want 1/7/104", rf_we, rf_waddr, rf_wdata); else n_pass++;
        drive(1, 1, 1, 3'b010, 2'd0, 5'd8, 32'h99, 32'h0000_0104);
        tick();
        idle();
        mem_rvalid = 1;
        mem_rdata  = 32'h0000_FFFF;
        tick();
        idle();
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h0000_0104) $display("FAIL pc2reg_load got %b/%0d/%h want 1/8/104", rf_we, rf_waddr, rf_wdata); else n_pass++;
    endtask

    task automatic test_backpressure();
        drive(1, 1, 0, 3'b010, 2'd0, 5'd1, 32'h0, 32'h0);
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one got %b want 1", in_ready); else n_pass++;
        drive(0, 1, 0, 3'b000, 2'd0, 5'd2, 32'h22, 32'h0);
        tick();
        drive(0, 1, 0, 3'b000, 2'd0, 5'd3, 32'h33, 32'h0);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (in_ready !== 1'b0 || rf_we !== 1'b0) $display("FAIL bp_stall%0d got ready=%b we=%b want 0/0", i, in_ready, rf_we); else n_pass++;
            tick();
        end
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_at_rsp got %b want 0", in_ready); else n_pass++;
        mem_rvalid = 1;
        mem_rdata  = 32'h0000_00AA;
        tick();
        mem_rvalid = 0;
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'hAA) $display("FAIL bp_load got %b/%0d/%h want 1/1/aa", rf_we, rf_waddr, rf_wdata); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after got %b want 1", in_ready); else n_pass++;
        tick();
        idle();
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22) $display("FAIL bp_second got %b/%0d/%h want 1/2/22", rf_we, rf_waddr, rf_wdata); else n_pass++;
        tick();
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33) $display("FAIL bp_third got %b/%0d/%h want 1/3/33", rf_we, rf_waddr, rf_wdata); else n_pass++;
        tick();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL bp_drain got %b want 0", rf_we); else n_pass++;
    endtask

    task automatic test_err_rsp();
        n_checks++; if (err_rsp !== 1'b0) $display("FAIL rsp_clean got %b want 0", err_rsp); else n_pass++;
        mem_rvalid = 1;
        mem_rdata  = 32'h1;
        tick();
        idle();
        n_checks++; if (err_rsp !== 1'b1 || rf_we !== 1'b0) $display("FAIL rsp_empty got err=%b we=%b want 1/0", err_rsp, rf_we); else n_pass++;
        tick();
        n_checks++; if (err_rsp !== 1'b1) $display("FAIL rsp_sticky got %b want 1", err_rsp); else n_pass++;
        drive(1, 1, 0, 3'b100, 2'd1, 5'd6, 32'h0, 32'h0);
        tick();
        idle();
        mem_rvalid = 1;
        mem_rdata  = 32'h0000_AB00;
        tick();
        idle();
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h0000_00AB) $display("FAIL rsp_next_load got %b/%0d/%h want 1/6/ab", rf_we, rf_waddr, rf_wdata); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 3'b010, 2'd0, 5'd9, 32'h0, 32'h0);
        tick();
        idle();
        #2;
        rst_n = 0;
        #1;
        n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) $display("FAIL mid_rst_rf got %b/%0d/%h want 0/0/0", rf_we, rf_waddr, rf_wdata); else n_pass++;
        n_checks++; if (err_rsp !== 1'b0 || err_f3 !== 1'b0) $display("FAIL mid_rst_err got %b%b want 00", err_rsp, err_f3); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", in_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        mem_rvalid = 1;
        mem_rdata  = 32'h0000_0009;
        tick();
        idle();
        n_checks++; if (err_rsp !== 1'b1 || rf_we !== 1'b0) $display("FAIL mid_rst_discard got err=%b we=%b want 1/0", err_rsp, rf_we); else n_pass++;
        drive(0, 1, 0, 3'b000, 2'd0, 5'd4, 32'h44, 32'h0);
        tick();
        idle();
        tick();
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44) $display("FAIL mid_rst_alu got %b/%0d/%h want 1/4/44", rf_we, rf_waddr, rf_wdata); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready_after got %b want 1", in_ready); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_loads();
        test_rd0_pc2reg();
        test_backpressure();
        test_err_rsp();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
